// File: rtl/lfsr_pkg.sv
// Shared types and default constants for the dual-mode LFSR.
// The optional zero-state guard in the top is selected with LFSR_ZERO_GUARD_EN.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  localparam int         LFSR_WIDTH    = 4;
  // Both masks describe x^4 + x^3 + 1, which is maximal length (period 15).
  localparam logic [3:0] LFSR_FIB_TAPS = 4'b1100;
  localparam logic [3:0] LFSR_GAL_MASK = 4'b1100;

  // Value substituted for the all-zero lock-up state when the guard is built in.
  localparam int         ZERO_SUB      = 1;

endpackage : lfsr_pkg

// File: rtl/lfsr_next.sv
// Combinational next-state function for the LFSR.
// Fibonacci: shift left, and the XOR of the tapped bits enters at bit 0.
// Galois: shift right, and bit 0 toggles the masked positions.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] FIB_TAPS = LFSR_FIB_TAPS,
  parameter logic [WIDTH-1:0] GAL_MASK = LFSR_GAL_MASK
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] next_o
);

  lfsr_mode_e       mode;
  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;

  assign mode = lfsr_mode_e'(sel_i);

  // Fibonacci step: external XOR of tapped bits shifted in at the LSB.
  always_comb begin
    fib_fb   = ^(state_i & FIB_TAPS);
    fib_next = {state_i[WIDTH-2:0], fib_fb};
  end

  // Galois step: the bit shifted out decides whether the mask toggles the register.
  always_comb begin
    gal_next = {1'b0, state_i[WIDTH-1:1]};
    if (state_i[0]) begin
      gal_next = gal_next ^ GAL_MASK;
    end
  end

  // Mode select; sel is applied combinationally so a change takes effect on the next edge.
  always_comb begin
    next_o = fib_next;
    case (mode)
      LFSR_FIB: next_o = fib_next;
      LFSR_GAL: next_o = gal_next;
      default:  next_o = fib_next;
    endcase
  end

endmodule : lfsr_next

// File: rtl/lfsr.sv
// Dual-mode (Fibonacci / Galois) pseudorandom generator.
// The seed is captured on the first clock edge after reset release; every later
// edge advances one step in the mode chosen by sel. Defining LFSR_ZERO_GUARD_EN
// replaces the all-zero lock-up state (and a zero seed) with 0...01.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] FIB_TAPS = LFSR_FIB_TAPS,
  parameter logic [WIDTH-1:0] GAL_MASK = LFSR_GAL_MASK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             sel,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             load_pend_q;
  logic             load_pend_d;
  logic [WIDTH-1:0] step_next;

  lfsr_next #(
    .WIDTH    (WIDTH),
    .FIB_TAPS (FIB_TAPS),
    .GAL_MASK (GAL_MASK)
  ) u_next (
    .state_i (state_q),
    .sel_i   (sel),
    .next_o  (step_next)
  );

`ifdef LFSR_ZERO_GUARD_EN
  localparam logic [WIDTH-1:0] ZERO_VAL = WIDTH'(ZERO_SUB);

  // Load the seed once, then step; any zero value is replaced so the register never locks up.
  always_comb begin
    state_d     = state_q;
    load_pend_d = load_pend_q;
    if (load_pend_q) begin
      load_pend_d = 1'b0;
      state_d     = (seed == '0) ? ZERO_VAL : seed;
    end else if (state_q == '0) begin
      state_d = ZERO_VAL;
    end else begin
      state_d = step_next;
    end
  end
`else
  // Load the seed once, then step; a zero seed stays zero because zero maps to zero in both modes.
  always_comb begin
    state_d     = state_q;
    load_pend_d = load_pend_q;
    if (load_pend_q) begin
      load_pend_d = 1'b0;
      state_d     = seed;
    end else begin
      state_d = step_next;
    end
  end
`endif

  // State and pending-load registers; reset clears the state and re-arms the seed load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= '0;
      load_pend_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign state = state_q;

endmodule : lfsr

// File: tb/tb_lfsr.sv
// Directed bench for the dual-mode LFSR (default 4-bit, x^4+x^3+1 taps).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_lfsr;

  logic       clk;
  logic       rst;
  logic [3:0] seed;
  logic       sel;
  logic [3:0] state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  lfsr dut (
    .clk   (clk),
    .rst   (rst),
    .seed  (seed),
    .sel   (sel),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset for two edges with the given inputs, release, and take the load edge.
  task automatic start(input logic [3:0] s, input logic m);
    rst  = 1'b0;
    seed = s;
    sel  = m;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    seed = 4'b1111;
    sel  = 1'b0;
    #1;
    total_cnt++;
    if (state !== 4'b0000) $display("FAIL reset_async: got %b want 0000", state);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (state !== 4'b0000) $display("FAIL reset_hold: got %b want 0000", state);
    else pass_cnt++;
    rst = 1'b1;
    step();
    total_cnt++;
    if (state !== 4'b1111) $display("FAIL reset_load: got %b want 1111", state);
    else pass_cnt++;
  endtask

  task automatic test_fib();
    logic [3:0] exp_seq [7];
    exp_seq = '{4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001};
    start(4'b1111, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step();
      total_cnt++;
      if (state !== exp_seq[i]) $display("FAIL fib_step%0d: got %b want %b", i + 1, state, exp_seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_gal();
    logic [3:0] exp_seq [7];
    exp_seq = '{4'b1011, 4'b1001, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100};
    start(4'b1111, 1'b1);
    total_cnt++;
    if (state !== 4'b1111) $display("FAIL gal_load: got %b want 1111", state);
    else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      step();
      total_cnt++;
      if (state !== exp_seq[i]) $display("FAIL gal_step%0d: got %b want %b", i + 1, state, exp_seq[i]);
      else pass_cnt++;
    end
    for (int i = 7; i < 15; i++) step();
    total_cnt++;
    if (state !== 4'b1111) $display("FAIL gal_period: got %b want 1111", state);
    else pass_cnt++;
  endtask

  task automatic test_mode_switch();
    start(4'b1111, 1'b0);
    for (int i = 0; i < 5; i++) step();
    total_cnt++;
    if (state !== 4'b0010) $display("FAIL switch_pre: got %b want 0010", state);
    else pass_cnt++;
    sel = 1'b1;
    step();
    total_cnt++;
    if (state !== 4'b0001) $display("FAIL switch_gal1: got %b want 0001", state);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 4'b1100) $display("FAIL switch_gal2: got %b want 1100", state);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    start(4'b1111, 1'b0);
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (state !== 4'b0000) $display("FAIL midrst_async: got %b want 0000", state);
    else pass_cnt++;
    seed = 4'b1010;
    @(negedge clk);
    step();
    total_cnt++;
    if (state !== 4'b0000) $display("FAIL midrst_hold: got %b want 0000", state);
    else pass_cnt++;
    rst = 1'b1;
    step();
    total_cnt++;
    if (state !== 4'b1010) $display("FAIL midrst_reload: got %b want 1010", state);
    else pass_cnt++;
    seed = 4'b0011;
    step();
    total_cnt++;
    if (state !== 4'b0101) $display("FAIL seed_ignored1: got %b want 0101", state);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 4'b1011) $display("FAIL seed_ignored2: got %b want 1011", state);
    else pass_cnt++;
  endtask

  task automatic test_zero_seed();
    start(4'b0000, 1'b0);
`ifdef LFSR_ZERO_GUARD_EN
    total_cnt++;
    if (state !== 4'b0001) $display("FAIL zero_load: got %b want 0001", state);
    else pass_cnt++;
    step();
    total_cnt++;
    if (state !== 4'b0010) $display("FAIL zero_step: got %b want 0010", state);
    else pass_cnt++;
`else
    begin
      int nonzero_seen = 0;
      total_cnt++;
      if (state !== 4'b0000) $display("FAIL zero_load: got %b want 0000", state);
      else pass_cnt++;
      for (int i = 0; i < 20; i++) begin
        step();
        if (state !== 4'b0000) nonzero_seen++;
      end
      total_cnt++;
      if (nonzero_seen != 0) $display("FAIL zero_lockup: %0d nonzero edges, want 0 (last %b)", nonzero_seen, state);
      else pass_cnt++;
    end
`endif
  endtask

  task automatic test_exhaustive();
    for (int m = 0; m < 2; m++) begin
      for (int s = 1; s < 16; s++) begin
        logic [15:0] seen;
        int          errs;
        logic [3:0]  bad;
        seen = '0;
        errs = 0;
        bad  = '0;
        start(4'(s), m[0]);
        for (int k = 1; k <= 15; k++) begin
          step();
          if (k < 15) begin
            if (state == 4'(s) || state == 4'b0000 || seen[state]) begin
              errs++;
              bad = state;
            end
            seen[state] = 1'b1;
          end else if (state !== 4'(s)) begin
            errs++;
            bad = state;
          end
        end
        total_cnt++;
        if (errs != 0) $display("FAIL exhaustive_mode%0d_seed%0d: %0d bad steps (last %b), want period 15", m, s, errs, bad);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst  = 1'b0;
    seed = 4'b0000;
    sel  = 1'b0;
    @(negedge clk);
    test_reset();
    test_fib();
    test_gal();
    test_mode_switch();
    test_reset_mid();
    test_zero_seed();
    test_exhaustive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_lfsr
